perm_unrank: RTL and testbench

PERM_UNRANK -- requirements
Module: perm_unrank

---
 rtl/perm_pkg.sv | 39 +++
 rtl/perm_pick.sv | 30 +++
 rtl/perm_unrank.sv | 108 ++++++++++
 tb/tb_perm_unrank.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/perm_pkg.sv
// rtl/perm_pkg.sv - shared sizes, factorial constants and FSM states for perm_unrank
// Purpose: single source of element count, widths, rank limit and factorials.
// Ports: none (package).
package perm_pkg;

  localparam int          N_EL        = 8;
  localparam int          EL_W        = 3;
  localparam int          ORDER_W     = 24;
  localparam logic [15:0] MAX_RANK    = 16'd40319;
  localparam logic [23:0] IDENT_ORDER = 24'h053977;

  localparam logic [15:0] FACT7 = 16'd5040;
  localparam logic [15:0] FACT6 = 16'd720;
  localparam logic [15:0] FACT5 = 16'd120;
  localparam logic [15:0] FACT4 = 16'd24;
  localparam logic [15:0] FACT3 = 16'd6;
  localparam logic [15:0] FACT2 = 16'd2;
  localparam logic [15:0] FACT1 = 16'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // k! for k = 0..7; only ever called with elaboration-time constants.
  function automatic logic [15:0] fact(input int k);
    case (k)
      7:       fact = FACT7;
      6:       fact = FACT6;
      5:       fact = FACT5;
      4:       fact = FACT4;
      3:       fact = FACT3;
      2:       fact = FACT2;
      default: fact = FACT1;
    endcase
  endfunction

endpackage

// File: rtl/perm_pick.sv
// rtl/perm_pick.sv - select the d-th unused element index from a used mask
// Purpose: combinational; returns the index of the d-th (0-based) clear bit.
// Ports: used (8-bit mask, 1 = taken), d (3-bit ordinal), el (3-bit index).
module perm_pick
  import perm_pkg::*;
(
  input  logic [N_EL-1:0] used,
  input  logic [EL_W-1:0] d,
  output logic [EL_W-1:0] el
);

  logic [3:0] cnt;
  logic       found;

  always_comb begin
    el    = '0;
    cnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N_EL; i++) begin
      if (!used[i]) begin
        if (!found && (cnt == {1'b0, d})) begin
          el    = EL_W'(i);
          found = 1'b1;
        end
        cnt = cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/perm_unrank.sv
// rtl/perm_unrank.sv - decode a lexicographic rank into a permutation of 0..7
// Purpose: factorial-base unranking, one output position per CALC cycle.
// Ports: CLK, RST (async active-low), start/index (request),
//        busy, valid (1-cycle pulse), err (rank out of range), order (24-bit result).
module perm_unrank
  import perm_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [15:0]        index,
  output logic               busy,
  output logic               valid,
  output logic               err,
  output logic [ORDER_W-1:0] order
);

  state_t          state, state_nxt;
  logic [15:0]     remainder;
  logic [N_EL-1:0] used;
  logic [2:0]      step;
  logic [2:0]      k_cur;
  logic [2:0]      d_sel;
  logic [15:0]     sub_sel;
  logic [EL_W-1:0] pick_el;
  logic            rank_bad;

  // k = 7 - step, which for a 3-bit step is its bitwise inverse.
  assign k_cur    = ~step;
  assign rank_bad = (index > MAX_RANK);

  // Comparator ladder: d counts how many constants j*k! (j=1..k) the
  // remainder reaches. Every product is folded at elaboration, so the only
  // runtime multiply is d times a constant.
  always_comb begin
    d_sel   = '0;
    sub_sel = '0;
    for (int kk = 0; kk < N_EL; kk++) begin
      if (k_cur == kk[2:0]) begin
        for (int j = 1; j < N_EL; j++) begin
          if ((j <= kk) && (remainder >= 16'(j) * fact(kk)))
            d_sel = d_sel + 3'd1;
        end
        sub_sel = 16'(d_sel) * fact(kk);
      end
    end
  end

  perm_pick u_pick (
    .used (used),
    .d    (d_sel),
    .el   (pick_el)
  );

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = rank_bad ? ST_DONE : ST_CALC;
      ST_CALC: if (step == 3'd7) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy  = (state != ST_IDLE);
    valid = (state == ST_DONE);
  end

  // Datapath. order is only touched during CALC, so an out-of-range request
  // leaves the previous result in place.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      remainder <= '0;
      used      <= '0;
      step      <= '0;
      err       <= 1'b0;
      order     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            remainder <= index;
            used      <= '0;
            step      <= '0;
            err       <= rank_bad;
          end
        end
        ST_CALC: begin
          order[3*int'(k_cur) +: EL_W] <= pick_el;
          used[pick_el]                <= 1'b1;
          remainder                    <= remainder - sub_sel;
          step                         <= step + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perm_unrank.sv
// tb/tb_perm_unrank.sv - scoreboard bench for perm_unrank
module tb_perm_unrank;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [15:0] index = '0;
  logic        busy, valid, err;
  logic [23:0] order;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] ord;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] last_ord = '0;

  perm_unrank dut (
    .CLK   (CLK),
    .RST   (RST),
    .start (start),
    .index (index),
    .busy  (busy),
    .valid (valid),
    .err   (err),
    .order (order)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Reference: long division in factorial base, independent of the RTL ladder.
  function automatic logic [23:0] model(input int rank);
    logic [7:0]  av;
    logic [23:0] o;
    int r, f, d, cnt;
    av = 8'hFF;
    o  = '0;
    r  = rank;
    for (int k = 7; k >= 0; k--) begin
      f = 1;
      for (int m = 2; m <= k; m++) f = f * m;
      d   = r / f;
      r   = r % f;
      cnt = 0;
      for (int v = 0; v < 8; v++) begin
        if (av[v]) begin
          if (cnt == d) begin
            o[3*k +: 3] = 3'(v);
            av[v] = 1'b0;
          end
          cnt++;
        end
      end
    end
    return o;
  endfunction

  function automatic logic is_perm(input logic [23:0] o);
    logic [7:0] seen;
    seen = '0;
    for (int i = 0; i < 8; i++) seen[o[3*i +: 3]] = 1'b1;
    return (seen == 8'hFF);
  endfunction

  task automatic run(input int idx, output logic [23:0] got);
    exp_t e;
    int   lat;
    e.err = (idx > 40319);
    e.ord = e.err ? last_ord : model(idx);
    e.lat = e.err ? 1 : 9;
    sb.push_back(e);
    @(negedge CLK);
    start = 1'b1;
    index = 16'(idx);
    @(posedge CLK);
    #1 start = 1'b0;
    lat = 1;
    @(negedge CLK);
    while (!valid && lat < 20) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    e = sb.pop_front();
    if (!valid) begin
      chk("timeout_valid", 32'(valid), 32'd1);
    end else begin
      chk("order", 32'(order), 32'(e.ord));
      chk("err", 32'(err), 32'(e.err));
      chk("latency", 32'(lat), 32'(e.lat));
    end
    got = order;
    if (!e.err) last_ord = e.ord;
    @(negedge CLK);
    chk("valid_pulse_end", 32'(valid), 32'd0);
  endtask

  initial begin : main
    logic [23:0] got, prev;
    exp_t        e;
    int          pulses;

    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_order", 32'(order), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    run(0, got);      chk("r0_lit", 32'(got), 32'h053977);
    run(1, got);      chk("r1_lit", 32'(got), 32'h05397E);
    run(5040, got);   chk("r5040_lit", 32'(got), 32'h213977);
    run(40319, got);  chk("rmax_lit", 32'(got), 32'hFAC688);
    run(40320, got);  chk("oob_hold", 32'(got), 32'hFAC688);
    run(65535, got);  chk("oob2_hold", 32'(got), 32'hFAC688);
    run(12345, got);

    // Second start during CALC must be ignored.
    e.ord = model(100); e.err = 1'b0; e.lat = 9;
    sb.push_back(e);
    @(negedge CLK); start = 1'b1; index = 16'd100;
    @(posedge CLK); #1 start = 1'b0;
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK); start = 1'b1; index = 16'd200;
    @(posedge CLK); #1 start = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge CLK);
      if (valid) begin
        pulses++;
        if (pulses == 1) begin
          e = sb.pop_front();
          chk("ign_order", 32'(order), 32'(e.ord));
          chk("ign_err", 32'(err), 32'(e.err));
        end
      end
    end
    chk("ign_pulses", 32'(pulses), 32'd1);
    chk("ign_idle", 32'(busy), 32'd0);
    last_ord = model(100);

    // Reset in the middle of CALC.
    @(negedge CLK); start = 1'b1; index = 16'd300;
    @(posedge CLK); #1 start = 1'b0;
    repeat (4) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_order", 32'(order), 32'd0);
    pulses = 0;
    repeat (12) begin
      @(negedge CLK);
      if (valid) pulses++;
    end
    chk("mid_rst_no_valid", 32'(pulses), 32'd0);
    RST = 1'b1;
    last_ord = '0;
    run(40320, got);  chk("post_rst_oob", 32'(got), 32'd0);
    run(0, got);      chk("post_rst_r0", 32'(got), 32'h053977);

    // Consecutive-rank windows at both ends of the range.
    prev = '0;
    for (int r = 0; r < 1500; r++) begin
      run(r, got);
      chk("sweep_perm", 32'(is_perm(got)), 32'd1);
      if (r > 0) chk("sweep_incr", 32'(got > prev), 32'd1);
      prev = got;
    end
    for (int r = 38820; r <= 40319; r++) begin
      run(r, got);
      chk("sweep_perm", 32'(is_perm(got)), 32'd1);
      if (r > 38820) chk("sweep_incr", 32'(got > prev), 32'd1);
      prev = got;
    end

    for (int i = 0; i < 40; i++) begin
      run(int'($urandom_range(0, 40319)), got);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
